// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
//   Shared types and helpers for the stream_mux_arb slice.
//   arb_mode_e  : arbitration policy selected at elaboration time
//   mux_state_e : packet-lock state of the multiplexer FSM
//   wrapInc     : modulo-n increment that wraps explicitly, so it stays
//                 correct when the channel count is not a power of two
package stream_mux_pkg;

  typedef enum logic [1:0] {
    ARB_RR,
    ARB_FIXED,
    ARB_EXT
  } arb_mode_e;

  typedef enum logic {
    IDLE,
    LOCKED
  } mux_state_e;

  // Returns (idx + 1) mod n. The compare-and-reset form is used instead of
  // dropping carry bits because n is generally not a power of two.
  function automatic int unsigned wrapInc(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end
    return idx + 32'd1;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_picker.sv
// rr_picker
//   Purely combinational candidate selector for stream_mux_arb.
//   Ports:
//     req   in  [NumInputs-1:0] : per-channel request (input valid)
//     ptr   in  [SelW-1:0]      : search start for ARB_RR, requested
//                                 channel for ARB_EXT, ignored for ARB_FIXED
//     mode  in  arb_mode_e      : arbitration policy
//     found out 1               : a candidate exists
//     index out [SelW-1:0]      : the chosen channel (0 when found is low)
module rr_picker
  import stream_mux_pkg::*;
#(
  parameter int NumInputs = 8,
  parameter int SelW      = $clog2(NumInputs)
) (
  input  logic [NumInputs-1:0] req,
  input  logic [SelW-1:0]      ptr,
  input  arb_mode_e            mode,
  output logic                 found,
  output logic [SelW-1:0]      index
);

  // Requests padded out to the full index range, so any SelW-bit index
  // (including ones past the last real channel) reads a defined zero.
  localparam int PadW = 1 << SelW;

  logic [PadW-1:0] reqPad;

  assign reqPad = PadW'(req);

  // Candidate search. The loops run from the far end towards the preferred
  // end so the last hit written is the one with the highest priority.
  always_comb begin
    int cand;
    found = 1'b0;
    index = '0;
    cand  = 0;
    case (mode)
      ARB_FIXED: begin
        for (int i = NumInputs - 1; i >= 0; i--) begin
          if (reqPad[SelW'(i)]) begin
            found = 1'b1;
            index = SelW'(i);
          end
        end
      end
      ARB_EXT: begin
        // An out-of-range select never grants, even though the padded
        // vector would read zero there anyway.
        if ((int'(ptr) < NumInputs) && reqPad[ptr]) begin
          found = 1'b1;
          index = ptr;
        end
      end
      default: begin
        for (int off = NumInputs - 1; off >= 0; off--) begin
          cand = int'(ptr) + off;
          if (cand >= NumInputs) begin
            cand = cand - NumInputs;
          end
          if (reqPad[SelW'(cand)]) begin
            found = 1'b1;
            index = SelW'(cand);
          end
        end
      end
    endcase
  end

endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb
//   N-input valid/ready stream multiplexer with packet-level locking and a
//   registered output stage. A channel is chosen in IDLE, then served
//   exclusively until its inLast beat is accepted.
//   Ports:
//     clk, rst                 : clock (rising edge), async active-high reset
//     inValid/inData/inLast    : per-channel producer side
//     inReady                  : per-channel accept, only the granted bit
//                                can be high
//     selectIn                 : requested channel, used when Mode==ARB_EXT
//     outValid/outData/outLast : registered output beat
//     outChannel               : source channel of the output beat
//     outReady                 : downstream accept
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int        Width     = 8,
  parameter int        NumInputs = 8,
  parameter arb_mode_e Mode      = ARB_RR,
  parameter int        SelW      = $clog2(NumInputs)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NumInputs-1:0] inValid,
  input  logic [Width-1:0]     inData [0:NumInputs-1],
  input  logic [NumInputs-1:0] inLast,
  output logic [NumInputs-1:0] inReady,
  input  logic [SelW-1:0]      selectIn,
  output logic                 outValid,
  output logic [Width-1:0]     outData,
  output logic                 outLast,
  output logic [SelW-1:0]      outChannel,
  input  logic                 outReady
);

  mux_state_e       state;
  mux_state_e       stateNext;
  logic [SelW-1:0]  rrPtr;
  logic [SelW-1:0]  grant;
  logic [SelW-1:0]  pickPtr;
  logic [SelW-1:0]  pickIndex;
  logic             pickFound;
  logic             grantValid;
  logic             grantLast;
  logic [Width-1:0] grantData;
  logic             acceptBeat;
  logic             handshake;

  // The picker's pointer input doubles as the external select in ARB_EXT,
  // which keeps the picker interface mode-agnostic.
  assign pickPtr = (Mode == ARB_EXT) ? selectIn : rrPtr;

  rr_picker #(
    .NumInputs(NumInputs),
    .SelW     (SelW)
  ) uPicker (
    .req  (inValid),
    .ptr  (pickPtr),
    .mode (Mode),
    .found(pickFound),
    .index(pickIndex)
  );

  // Route the granted channel's valid/data/last to the output stage.
  always_comb begin
    grantValid = 1'b0;
    grantData  = '0;
    grantLast  = 1'b0;
    for (int i = 0; i < NumInputs; i++) begin
      if (grant == SelW'(i)) begin
        grantValid = inValid[i];
        grantData  = inData[i];
        grantLast  = inLast[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next state and inReady. The granted channel may push whenever the
  // output register is empty or draining this cycle, which gives one beat
  // per cycle under continuous outReady.
  always_comb begin
    stateNext  = state;
    inReady    = '0;
    acceptBeat = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (pickFound) begin
          stateNext = LOCKED;
        end
      end
      LOCKED: begin
        acceptBeat = !outValid || outReady;
        for (int i = 0; i < NumInputs; i++) begin
          inReady[i] = acceptBeat && (grant == SelW'(i));
        end
        handshake = acceptBeat && grantValid;
        if (handshake && grantLast) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Grant is captured only in IDLE, so selectIn or request changes during a
  // packet cannot move the lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
    end else if ((state == IDLE) && pickFound) begin
      grant <= pickIndex;
    end
  end

  // Round-robin pointer moves past the channel whose packet just ended;
  // the other modes leave it frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr <= '0;
    end else if ((Mode == ARB_RR) && handshake && grantLast) begin
      rrPtr <= SelW'(wrapInc(32'(grant), NumInputs));
    end
  end

  // Output register. A load takes precedence over a drain, so a drain and a
  // load in the same cycle pass straight through without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid   <= 1'b0;
      outData    <= '0;
      outLast    <= 1'b0;
      outChannel <= '0;
    end else if (handshake) begin
      outValid   <= 1'b1;
      outData    <= grantData;
      outLast    <= grantLast;
      outChannel <= grant;
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb
//   Self-checking bench for stream_mux_arb. Four instances cover the
//   configurations of interest (RR/8, FIXED/5, RR/5, EXT/8); only the
//   active one receives traffic. Producers are per-channel beat queues with
//   optional stall gaps; a behavioural model built from the arbitration
//   rules predicts inReady and the output register each cycle.
module tb_stream_mux_arb;
  import stream_mux_pkg::*;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       last;
    int         stall;
  } beat_t;

  logic       clk;
  logic       rst;
  logic [7:0] inValid;
  logic [7:0] inData [0:7];
  logic [7:0] inLast;
  logic [2:0] selectIn;
  logic       outReady;

  logic [7:0] data5 [0:4];
  logic [7:0] v0, v3;
  logic [4:0] v1, v2;
  logic [7:0] rdy0, rdy3;
  logic [4:0] rdy1, rdy2;
  logic       ov0, ov1, ov2, ov3;
  logic [7:0] od0, od1, od2, od3;
  logic       ol0, ol1, ol2, ol3;
  logic [2:0] oc0, oc1, oc2, oc3;

  logic [7:0] obsReady;
  logic       obsOutValid;
  logic [7:0] obsOutData;
  logic       obsOutLast;
  logic [2:0] obsOutCh;

  int         active;
  int         numCh;
  arb_mode_e  mMode;
  int         readyPct;
  bit         extRandom;
  beat_t      beats[$];
  logic [7:0] hsMask;

  bit         mLocked;
  int         mCh;
  int         mPtr;
  bit         mOutValid;
  logic [7:0] mOutData;
  bit         mOutLast;
  int         mOutCh;

  int         obsOrder[$];
  bit         obsFirst;
  int         obsBeatCount;

  int         checkCount;
  int         errorCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 5; i++) data5[i] = inData[i];
  end

  assign v0 = (active == 0) ? inValid      : 8'h00;
  assign v1 = (active == 1) ? inValid[4:0] : 5'h00;
  assign v2 = (active == 2) ? inValid[4:0] : 5'h00;
  assign v3 = (active == 3) ? inValid      : 8'h00;

  stream_mux_arb #(.Width(8), .NumInputs(8), .Mode(ARB_RR)) dutRr8 (
    .clk(clk), .rst(rst), .inValid(v0), .inData(inData), .inLast(inLast),
    .inReady(rdy0), .selectIn(selectIn), .outValid(ov0), .outData(od0),
    .outLast(ol0), .outChannel(oc0), .outReady(outReady));

  stream_mux_arb #(.Width(8), .NumInputs(5), .Mode(ARB_FIXED)) dutFix5 (
    .clk(clk), .rst(rst), .inValid(v1), .inData(data5), .inLast(inLast[4:0]),
    .inReady(rdy1), .selectIn(selectIn), .outValid(ov1), .outData(od1),
    .outLast(ol1), .outChannel(oc1), .outReady(outReady));

  stream_mux_arb #(.Width(8), .NumInputs(5), .Mode(ARB_RR)) dutRr5 (
    .clk(clk), .rst(rst), .inValid(v2), .inData(data5), .inLast(inLast[4:0]),
    .inReady(rdy2), .selectIn(selectIn), .outValid(ov2), .outData(od2),
    .outLast(ol2), .outChannel(oc2), .outReady(outReady));

  stream_mux_arb #(.Width(8), .NumInputs(8), .Mode(ARB_EXT)) dutExt8 (
    .clk(clk), .rst(rst), .inValid(v3), .inData(inData), .inLast(inLast),
    .inReady(rdy3), .selectIn(selectIn), .outValid(ov3), .outData(od3),
    .outLast(ol3), .outChannel(oc3), .outReady(outReady));

  // Present the active instance's outputs under one set of names.
  always_comb begin
    obsReady = 8'h00; obsOutValid = 1'b0; obsOutData = 8'h00;
    obsOutLast = 1'b0; obsOutCh = 3'd0;
    case (active)
      0: begin obsReady = rdy0;          obsOutValid = ov0; obsOutData = od0; obsOutLast = ol0; obsOutCh = oc0; end
      1: begin obsReady = {3'b000, rdy1}; obsOutValid = ov1; obsOutData = od1; obsOutLast = ol1; obsOutCh = oc1; end
      2: begin obsReady = {3'b000, rdy2}; obsOutValid = ov2; obsOutData = od2; obsOutLast = ol2; obsOutCh = oc2; end
      3: begin obsReady = rdy3;          obsOutValid = ov3; obsOutData = od3; obsOutLast = ol3; obsOutCh = oc3; end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int frontIdx(input int ch);
    for (int i = 0; i < beats.size(); i++) begin
      if (beats[i].ch == ch) return i;
    end
    return -1;
  endfunction

  // Winner by the arbitration rules; -1 when nobody qualifies.
  function automatic int pickWinner(input logic [7:0] v, input int ptr, input int sel);
    if (mMode == ARB_FIXED) begin
      for (int k = 0; k < numCh; k++) if (v[k]) return k;
    end else if (mMode == ARB_EXT) begin
      if (sel < numCh && v[sel]) return sel;
    end else begin
      for (int k = 0; k < numCh; k++) if (v[(ptr + k) % numCh]) return (ptr + k) % numCh;
    end
    return -1;
  endfunction

  task automatic resetModel();
    mLocked = 0; mCh = 0; mPtr = 0; mOutValid = 0; mOutData = 8'h00;
    mOutLast = 0; mOutCh = 0;
    obsOrder.delete(); obsFirst = 1; obsBeatCount = 0;
  endtask

  task automatic queuePacket(input int ch, input int len, input logic [7:0] base,
                             input int firstStall, input int stallBeat, input int stallLen);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.ch = ch;
      b.data = base + 8'(i);
      b.last = (i == len - 1);
      b.stall = (i == 0) ? firstStall : ((i == stallBeat) ? stallLen : 0);
      beats.push_back(b);
    end
  endtask

  task automatic queueRandom(input int n);
    for (int p = 0; p < n; p++) begin
      queuePacket($urandom_range(numCh - 1), $urandom_range(4, 1), 8'($urandom),
                  $urandom_range(2), $urandom_range(3, 1), $urandom_range(2));
    end
  endtask

  // Drive producer outputs from queue fronts (stalled fronts stay invalid).
  task automatic applyStimulus();
    int fi;
    for (int ch = 0; ch < 8; ch++) begin
      fi = frontIdx(ch);
      if (fi >= 0 && beats[fi].stall == 0) begin
        inValid[ch] = 1'b1; inData[ch] = beats[fi].data; inLast[ch] = beats[fi].last;
      end else begin
        inValid[ch] = 1'b0; inData[ch] = 8'h00; inLast[ch] = 1'b0;
      end
    end
    outReady = ($urandom_range(99) < readyPct);
    if (extRandom) selectIn = 3'($urandom_range(7));
  endtask

  // Compare the DUT to the model, then advance the model by one clock.
  task automatic modelStep();
    logic [7:0] expReady;
    int w;
    bit hs, outHs;
    expReady = 8'h00;
    if (mLocked && (!mOutValid || outReady)) expReady[mCh] = 1'b1;
    checkOutput("inReady", obsReady, expReady);
    checkOutput("outValid", obsOutValid, mOutValid);
    if (mOutValid) begin
      checkOutput("outData", obsOutData, mOutData);
      checkOutput("outLast", obsOutLast, mOutLast);
      checkOutput("outChannel", obsOutCh, mOutCh);
    end
    if (obsOutValid && outReady) begin
      if (obsFirst) obsOrder.push_back(int'(obsOutCh));
      obsFirst = obsOutLast;
      obsBeatCount++;
    end
    hsMask = obsReady & inValid;
    outHs = mOutValid && outReady;
    hs = mLocked && expReady[mCh] && inValid[mCh];
    if (!mLocked) begin
      w = pickWinner(inValid, mPtr, int'(selectIn));
      if (w >= 0) begin mLocked = 1; mCh = w; end
    end else if (hs) begin
      mOutValid = 1; mOutData = inData[mCh]; mOutLast = inLast[mCh]; mOutCh = mCh;
      if (inLast[mCh]) begin
        mLocked = 0;
        if (mMode == ARB_RR) mPtr = (mCh + 1) % numCh;
      end
    end
    if (outHs && !hs) mOutValid = 0;
  endtask

  task automatic popAndAge();
    int fi;
    beat_t b;
    for (int ch = 0; ch < 8; ch++) begin
      fi = frontIdx(ch);
      if (fi >= 0) begin
        if (hsMask[ch]) begin
          beats.delete(fi);
        end else if (beats[fi].stall > 0) begin
          b = beats[fi]; b.stall--; beats[fi] = b;
        end
      end
    end
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus();
      @(negedge clk);
      modelStep();
      @(posedge clk);
      #1;
      popAndAge();
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((beats.size() > 0 || mLocked || mOutValid) && n < budget) begin
      runCycles(1);
      n++;
    end
    checkOutput(tag, (beats.size() > 0 || mLocked || mOutValid) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic startPhase(input int cfg);
    active = cfg;
    numCh = (cfg == 1 || cfg == 2) ? 5 : 8;
    mMode = (cfg == 1) ? ARB_FIXED : ((cfg == 3) ? ARB_EXT : ARB_RR);
    rst = 1'b1;
    beats.delete();
    inValid = 8'h00; inLast = 8'h00; selectIn = 3'd0; outReady = 1'b1;
    for (int i = 0; i < 8; i++) inData[i] = 8'h00;
    readyPct = 100; extRandom = 0;
    resetModel();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic checkOrder(input string tag, input int n, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    checkOutput({tag, "Len"}, obsOrder.size(), n);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s%0d", tag, i), (i < obsOrder.size()) ? obsOrder[i] : 32'hFF, e[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    active = 0;

    // Reset state and a few idle cycles.
    startPhase(0);
    checkOutput("rstOutValid", obsOutValid, 0);
    checkOutput("rstOutData", obsOutData, 0);
    checkOutput("rstOutLast", obsOutLast, 0);
    checkOutput("rstOutChannel", obsOutCh, 0);
    checkOutput("rstInReady", obsReady, 0);
    runCycles(4);

    // Round-robin fairness across channels 2, 5, 7.
    startPhase(0);
    queuePacket(2, 2, 8'hA0, 0, 0, 0);
    queuePacket(5, 2, 8'hB0, 0, 0, 0);
    queuePacket(7, 2, 8'hC0, 0, 0, 0);
    queuePacket(2, 2, 8'hA2, 0, 0, 0);
    drain("rrDrain", 200);
    checkOrder("rrOrder", 4, 2, 5, 7, 2);

    // Packet lock: channel 3 stalls 4 cycles mid-packet while channel 0 waits.
    startPhase(0);
    queuePacket(3, 3, 8'h30, 0, 1, 4);
    queuePacket(0, 2, 8'h10, 1, 0, 0);
    drain("lockDrain", 200);
    checkOrder("lockOrder", 2, 3, 0, 0, 0);

    // Backpressure: outReady low for 5 cycles mid-stream.
    startPhase(0);
    queuePacket(6, 8, 8'h60, 0, 0, 0);
    runCycles(4);
    readyPct = 0;
    runCycles(5);
    checkOutput("bpInReady", obsReady, 0);
    checkOutput("bpOutValid", obsOutValid, 1);
    readyPct = 100;
    drain("bpDrain", 200);
    checkOutput("bpBeatCount", obsBeatCount, 8);

    // Asynchronous reset in the middle of a packet, then recovery.
    startPhase(0);
    queuePacket(4, 5, 8'h40, 0, 0, 0);
    runCycles(3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", obsOutValid, 0);
    checkOutput("midRstInReady", obsReady, 0);
    checkOutput("midRstOutChannel", obsOutCh, 0);
    checkOutput("midRstOutData", obsOutData, 0);
    beats.delete();
    inValid = 8'h00;
    resetModel();
    @(posedge clk);
    #1;
    rst = 1'b0;
    queuePacket(1, 2, 8'h50, 0, 0, 0);
    drain("recoverDrain", 200);
    checkOrder("recoverOrder", 1, 1, 0, 0, 0);

    // Fixed priority with five channels.
    startPhase(1);
    queuePacket(1, 2, 8'h11, 0, 0, 0);
    queuePacket(4, 2, 8'h41, 0, 0, 0);
    queuePacket(1, 2, 8'h13, 0, 0, 0);
    queuePacket(4, 2, 8'h43, 0, 0, 0);
    drain("fixDrain", 200);
    checkOrder("fixOrder", 4, 1, 1, 4, 4);

    // Round-robin with five channels, pointer wrap after channel 4.
    startPhase(2);
    queuePacket(1, 2, 8'h11, 0, 0, 0);
    queuePacket(4, 2, 8'h41, 0, 0, 0);
    queuePacket(1, 2, 8'h13, 0, 0, 0);
    queuePacket(4, 2, 8'h43, 0, 0, 0);
    drain("rr5Drain", 200);
    checkOrder("rr5Order", 4, 1, 4, 1, 4);
    obsOrder.delete();
    queuePacket(3, 1, 8'h33, 0, 0, 0);
    queuePacket(0, 1, 8'h03, 0, 0, 0);
    drain("rr5WrapDrain", 200);
    checkOrder("rr5Wrap", 2, 0, 3, 0, 0);

    // External select.
    startPhase(3);
    selectIn = 3'd6;
    queuePacket(2, 2, 8'h20, 0, 0, 0);
    queuePacket(6, 4, 8'h60, 3, 2, 2);
    runCycles(3);
    checkOutput("extNoGrant", obsReady, 0);
    checkOutput("extNoValid", obsOutValid, 0);
    runCycles(3);
    selectIn = 3'd2;
    drain("extDrain", 200);
    checkOrder("extOrder", 2, 6, 2, 0, 0);

    // Randomized traffic in every configuration.
    for (int cfg = 0; cfg < 4; cfg++) begin
      startPhase(cfg);
      readyPct = 70;
      extRandom = (cfg == 3);
      queueRandom((cfg == 0) ? 30 : 20);
      drain($sformatf("rndDrain%0d", cfg), 4000);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
